// File: rtl/wall_renderer.sv
`default_nettype none
// ============================================================================
// Module      : wall_renderer
// Description : Column buffer filled by the ray tracer during VBLANK, and a
//               two-stage read pipeline that turns the VGA h/v position into
//               a sky / wall / floor pixel colour.
// Revision    : 1.0 - initial release
// ============================================================================
module wall_renderer #(
  parameter int unsigned COLS       = 640,
  parameter int unsigned H_CENTER   = 240,
  parameter logic [5:0]  SKY_RGB    = 6'b01_01_11,
  parameter logic [5:0]  FLOOR_RGB  = 6'b01_01_01,
  parameter logic [5:0]  WALL_X_RGB = 6'b11_00_00,
  parameter logic [5:0]  WALL_Y_RGB = 6'b10_00_00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       store,
  input  logic [9:0] column,
  input  logic       side,
  input  logic [7:0] height,
  input  logic [9:0] h,
  input  logic [9:0] v,
  input  logic       visible,
  output logic [5:0] rgb,
  output logic       trace_done
);

  // Port-width copies of the parameters so every compare is width-matched.
  localparam logic [9:0] c_COLS     = 10'(COLS);
  localparam logic [9:0] c_LAST_COL = 10'(COLS - 1);
  localparam logic [9:0] c_CENTER   = 10'(H_CENTER);
  localparam logic [7:0] c_MAX_H    = 8'd240;

  // Buffer entry layout: {side, height}.
  logic [8:0] mem_q [COLS];

  logic       wr_en;
  logic [7:0] wr_height;
  logic [8:0] wr_data;
  logic       rd_in_range;
  logic [9:0] rd_addr;

  logic [8:0] rd_q;
  logic [9:0] v1_q;
  logic       vis1_q;

  logic [9:0] top;
  logic [9:0] bot;
  logic [5:0] rgb_d;
  logic [5:0] rgb_q;
  logic       trace_done_d;
  logic       trace_done_q;

  // Write acceptance, height clamp and read-address guard.
  always_comb begin
    wr_en        = store && (column < c_COLS);
    wr_height    = (height > c_MAX_H) ? c_MAX_H : height;
    wr_data      = {side, wr_height};
    rd_in_range  = (h < c_COLS);
    rd_addr      = rd_in_range ? h : 10'd0;
    trace_done_d = wr_en && (column == c_LAST_COL);
  end

  // Buffer RAM: write port plus synchronous read (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[column] <= wr_data;
    end
    rd_q <= mem_q[rd_addr];
  end

  // Stage 1 control: carry the row and the visibility flag alongside the read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q   <= 10'd0;
      vis1_q <= 1'b0;
    end else begin
      v1_q   <= v;
      vis1_q <= visible && rd_in_range;
    end
  end

  // Stage 2 colour selection from the slice bounds around the centre row.
  always_comb begin
    top   = c_CENTER - {2'b00, rd_q[7:0]};
    bot   = c_CENTER + {2'b00, rd_q[7:0]};
    rgb_d = 6'd0;
    if (!vis1_q) begin
      rgb_d = 6'd0;
    end else if (v1_q < top) begin
      rgb_d = SKY_RGB;
    end else if (v1_q >= bot) begin
      rgb_d = FLOOR_RGB;
    end else begin
      rgb_d = rd_q[8] ? WALL_Y_RGB : WALL_X_RGB;
    end
  end

  // Output registers: pixel colour and the end-of-trace pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q        <= 6'd0;
      trace_done_q <= 1'b0;
    end else begin
      rgb_q        <= rgb_d;
      trace_done_q <= trace_done_d;
    end
  end

  assign rgb        = rgb_q;
  assign trace_done = trace_done_q;

endmodule
`default_nettype wire

// File: tb/tb_wall_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wall_renderer
// Description : Self-checking bench for wall_renderer with a behavioural
//               column-buffer model and randomized read/write streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wall_renderer;

  localparam logic [5:0] SKY    = 6'b01_01_11;
  localparam logic [5:0] FLOOR  = 6'b01_01_01;
  localparam logic [5:0] WALL_X = 6'b11_00_00;
  localparam logic [5:0] WALL_Y = 6'b10_00_00;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       store = 1'b0;
  logic [9:0] column = '0;
  logic       side = 1'b0;
  logic [7:0] height = '0;
  logic [9:0] h = '0;
  logic [9:0] v = '0;
  logic       visible = 1'b0;
  logic [5:0] rgb;
  logic       trace_done;

  int checks = 0;
  int errors = 0;

  // Reference model of the column buffer: clamped height and side per column.
  int m_h    [640];
  bit m_side [640];
  logic [5:0] rgb_q_exp [$];

  wall_renderer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .store      (store),
    .column     (column),
    .side       (side),
    .height     (height),
    .h          (h),
    .v          (v),
    .visible    (visible),
    .rgb        (rgb),
    .trace_done (trace_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Pixel colour from the screen-geometry rules.
  function automatic logic [5:0] model_rgb(int hh, int vv, bit vis);
    int top, bot;
    if (!vis || hh >= 640) return 6'd0;
    top = 240 - m_h[hh];
    bot = 240 + m_h[hh];
    if (vv < top) return SKY;
    if (vv >= bot) return FLOOR;
    return m_side[hh] ? WALL_Y : WALL_X;
  endfunction

  function automatic void model_write(int col, bit s, int ht);
    if (col < 640) begin
      m_h[col]    = (ht > 240) ? 240 : ht;
      m_side[col] = s;
    end
  endfunction

  // Single write cycle; store is dropped afterwards.
  task automatic wr(input int col, input bit s, input int ht);
    store  = 1'b1;
    column = 10'(col);
    side   = s;
    height = 8'(ht);
    step();
    model_write(col, s, ht);
    store = 1'b0;
  endtask

  // Hold a read position for two edges and compare with a fixed colour.
  task automatic rd(input string tag, input int hh, input int vv, input bit vis,
                    input logic [5:0] exp);
    h = 10'(hh);
    v = 10'(vv);
    visible = vis;
    step();
    step();
    chk(tag, rgb, exp);
  endtask

  // One streaming cycle: expectation is formed before the same-cycle write
  // lands in the model, since the read sees the old contents.
  task automatic cyc(input bit st, input int col, input bit s, input int ht,
                     input int hh, input int vv, input bit vis);
    logic td_exp;
    store   = st;
    column  = 10'(col);
    side    = s;
    height  = 8'(ht);
    h       = 10'(hh);
    v       = 10'(vv);
    visible = vis;
    rgb_q_exp.push_back(model_rgb(hh, vv, vis));
    td_exp = st && (col == 639);
    step();
    if (st) model_write(col, s, ht);
    chk1("stream_trace_done", trace_done, td_exp);
    if (rgb_q_exp.size() >= 2) chk("stream_rgb", rgb, rgb_q_exp.pop_front());
  endtask

  initial begin
    // Reset state
    #3;
    chk("reset_rgb", rgb, 6'd0);
    chk1("reset_trace_done", trace_done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Fill the whole buffer so every column has a defined model value.
    for (int c = 0; c < 640; c++) begin
      wr(c, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    end

    // Basic slice boundaries, height 100 centred on 240
    wr(10, 1'b0, 100);
    rd("col10_v139", 10, 139, 1'b1, SKY);
    rd("col10_v140", 10, 140, 1'b1, WALL_X);
    rd("col10_v339", 10, 339, 1'b1, WALL_X);
    rd("col10_v340", 10, 340, 1'b1, FLOOR);

    // Height clamp to full screen
    wr(5, 1'b1, 250);
    rd("col5_v0",   5, 0,   1'b1, WALL_Y);
    rd("col5_v479", 5, 479, 1'b1, WALL_Y);
    rd("col5_v240", 5, 240, 1'b1, WALL_Y);

    // Empty slice and blanking
    wr(7, 1'b0, 0);
    rd("col7_v239", 7, 239, 1'b1, SKY);
    rd("col7_v240", 7, 240, 1'b1, FLOOR);
    rd("col7_invisible", 7, 100, 1'b0, 6'd0);
    rd("h_out_of_range", 650, 100, 1'b1, 6'd0);

    // trace_done pulse and out-of-range write rejection
    store = 1'b1; column = 10'd639; side = 1'b1; height = 8'd20;
    step();
    model_write(639, 1'b1, 20);
    store = 1'b0;
    chk1("trace_done_pulse", trace_done, 1'b1);
    step();
    chk1("trace_done_single", trace_done, 1'b0);
    store = 1'b1; column = 10'd700; side = 1'b0; height = 8'd200;
    step();
    store = 1'b0;
    chk1("trace_done_col700", trace_done, 1'b0);
    rd("col639_after_700", 639, 240, 1'b1, WALL_Y);
    rd("col639_v219", 639, 219, 1'b1, SKY);

    // Same-cycle write and read: old value first, new value next
    wr(20, 1'b0, 10);
    store = 1'b1; column = 10'd20; side = 1'b1; height = 8'd50;
    h = 10'd20; v = 10'd235; visible = 1'b1;
    step();
    model_write(20, 1'b1, 50);
    store = 1'b0;
    step();
    chk("rw_collision_old", rgb, WALL_X);
    step();
    chk("rw_collision_new", rgb, WALL_Y);

    // Back-to-back scan of every column with random rows and writes
    rgb_q_exp.delete();
    for (int x = 0; x < 640; x++) begin
      cyc(1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 700)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
          x, int'($urandom_range(0, 524)), 1'b1);
    end
    // Fully random traffic, including invisible and off-screen reads
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0) ? 639 : int'($urandom_range(0, 700)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 700)), int'($urandom_range(0, 524)),
          1'($urandom_range(0, 1)));
    end
    cyc(1'b0, 0, 1'b0, 0, 0, 0, 1'b0);
    rgb_q_exp.delete();

    // Asynchronous reset mid-frame, then recovery with buffer retained
    wr(10, 1'b0, 100);
    rd("pre_reset", 10, 200, 1'b1, WALL_X);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_rgb", rgb, 6'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("post_reset_edge1", rgb, 6'd0);
    step();
    chk("post_reset_edge2", rgb, WALL_X);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
